// File: rtl/cordic_ctrl_pkg.sv
// rtl/cordic_ctrl_pkg.sv - shared types for the CORDIC flow controller
package cordic_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - saturating-at-zero up/down occupancy counter
module updown_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    // A decrement on an empty counter is dropped so the count never wraps.
    logic dec_eff;
    assign dec_eff = dec && (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec_eff) begin
            count <= count + WIDTH'(1);
        end else if (!inc && dec_eff) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/cordic_flow_ctrl.sv
// rtl/cordic_flow_ctrl.sv - credit-based issue/drain control around the cordic core
module cordic_flow_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int OUT_FIFO_DEPTH = 128,
    parameter int CNT_WIDTH      = $clog2(OUT_FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 flush,
    input  logic                 theta_empty,
    output logic                 theta_rd_en,
    output logic                 cordic_valid_in,
    input  logic                 cordic_valid_out,
    output logic                 out_wr_en,
    input  logic                 out_rd_en,
    output logic [CNT_WIDTH-1:0] in_flight,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic [1:0]           state,
    output logic                 err
);

    ctrl_state_t cur_state;
    ctrl_state_t next_state;

    logic             have_flight;
    logic             have_credit;
    logic [CNT_WIDTH:0] occupancy;

    assign have_flight = (in_flight != '0);
    assign occupancy   = {1'b0, in_flight} + {1'b0, out_count};
    assign have_credit = (occupancy < (CNT_WIDTH + 1)'(OUT_FIFO_DEPTH));

    assign theta_rd_en = (cur_state == ST_RUN) && enable && !flush &&
                         !theta_empty && have_credit;

    // Results still retire from in_flight during FLUSH; they are just not stored.
    assign out_wr_en = cordic_valid_out && have_flight && (cur_state != ST_FLUSH);

    assign state = cur_state;

    updown_counter #(.WIDTH(CNT_WIDTH)) u_in_flight (
        .clk   (clk),
        .reset (reset),
        .inc   (theta_rd_en),
        .dec   (cordic_valid_out),
        .count (in_flight)
    );

    updown_counter #(.WIDTH(CNT_WIDTH)) u_out_count (
        .clk   (clk),
        .reset (reset),
        .inc   (out_wr_en),
        .dec   (out_rd_en),
        .count (out_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_IDLE: begin
                if (enable && !flush) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    next_state = ST_FLUSH;
                end else if (!enable) begin
                    next_state = have_flight ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    next_state = ST_FLUSH;
                end else if (!have_flight) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (!have_flight) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Aligns the valid strobe with the theta FIFO's registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cordic_valid_in <= 1'b0;
        end else begin
            cordic_valid_in <= theta_rd_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (cordic_valid_out && !have_flight) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cordic_flow_ctrl.sv
// tb/tb_cordic_flow_ctrl.sv - directed self-checking bench for cordic_flow_ctrl
module tb_cordic_flow_ctrl;

    logic clk;
    logic reset;

    // small instance: OUT_FIFO_DEPTH=4
    logic       s_enable, s_flush, s_theta_empty, s_cvo, s_out_rd;
    logic       s_rd, s_cvi, s_wr, s_err;
    logic [2:0] s_in_flight, s_out_count;
    logic [1:0] s_state;

    // big instance: OUT_FIFO_DEPTH=128
    logic       b_enable, b_flush, b_theta_empty, b_cvo, b_out_rd;
    logic       b_rd, b_cvi, b_wr, b_err;
    logic [7:0] b_in_flight, b_out_count;
    logic [1:0] b_state;

    int checks;
    int failures;
    int issues;
    int wr_seen;
    logic hist [0:15];

    cordic_flow_ctrl #(.OUT_FIFO_DEPTH(4)) dut_s (
        .clk              (clk),
        .reset            (reset),
        .enable           (s_enable),
        .flush            (s_flush),
        .theta_empty      (s_theta_empty),
        .theta_rd_en      (s_rd),
        .cordic_valid_in  (s_cvi),
        .cordic_valid_out (s_cvo),
        .out_wr_en        (s_wr),
        .out_rd_en        (s_out_rd),
        .in_flight        (s_in_flight),
        .out_count        (s_out_count),
        .state            (s_state),
        .err              (s_err)
    );

    cordic_flow_ctrl #(.OUT_FIFO_DEPTH(128)) dut_b (
        .clk              (clk),
        .reset            (reset),
        .enable           (b_enable),
        .flush            (b_flush),
        .theta_empty      (b_theta_empty),
        .theta_rd_en      (b_rd),
        .cordic_valid_in  (b_cvi),
        .cordic_valid_out (b_cvo),
        .out_wr_en        (b_wr),
        .out_rd_en        (b_out_rd),
        .in_flight        (b_in_flight),
        .out_count        (b_out_count),
        .state            (b_state),
        .err              (b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        issues = 0;
        wr_seen = 0;
        for (int i = 0; i < 16; i++) hist[i] = 1'b0;
        reset = 1'b1;
        s_enable = 0; s_flush = 0; s_theta_empty = 1; s_cvo = 0; s_out_rd = 0;
        b_enable = 0; b_flush = 0; b_theta_empty = 1; b_cvo = 0; b_out_rd = 0;
        #2;
        check("rst_state", s_state, 0);
        check("rst_rd", s_rd, 0);
        check("rst_cvi", s_cvi, 0);
        check("rst_wr", s_wr, 0);
        check("rst_in_flight", s_in_flight, 0);
        check("rst_out_count", s_out_count, 0);
        check("rst_err", s_err, 0);
        tick; tick;
        reset = 1'b0;

        // single angle (depth 128)
        b_enable = 1; tick;
        check("one_state_run", b_state, 1);
        b_theta_empty = 0; #1;
        check("one_rd", b_rd, 1);
        tick; b_theta_empty = 1; #1;
        check("one_rd_off", b_rd, 0);
        check("one_cvi", b_cvi, 1);
        check("one_in_flight", b_in_flight, 1);
        tick;
        check("one_cvi_off", b_cvi, 0);
        b_cvo = 1; #1;
        check("one_wr", b_wr, 1);
        tick; b_cvo = 0; #1;
        check("one_in_flight_0", b_in_flight, 0);
        check("one_out_count", b_out_count, 1);
        b_out_rd = 1; tick; b_out_rd = 0; #1;
        check("one_pop", b_out_count, 0);

        // simultaneous issue/result/pop (depth 128)
        b_theta_empty = 0; tick; tick; b_theta_empty = 1;
        b_cvo = 1; tick; tick; b_cvo = 0;
        b_theta_empty = 0; tick; tick;
        check("sim_pre_in_flight", b_in_flight, 2);
        check("sim_pre_out_count", b_out_count, 2);
        b_cvo = 1; b_out_rd = 1; #1;
        check("sim_rd", b_rd, 1);
        check("sim_wr", b_wr, 1);
        tick; b_cvo = 0; b_out_rd = 0; b_theta_empty = 1; #1;
        check("sim_in_flight", b_in_flight, 2);
        check("sim_out_count", b_out_count, 2);

        // flush (depth 128): 5 in flight, out_count 2
        b_theta_empty = 0; tick; tick; tick; b_theta_empty = 1; #1;
        check("fl_in_flight", b_in_flight, 5);
        b_flush = 1; b_theta_empty = 0; #1;
        check("fl_rd_blocked", b_rd, 0);
        tick; b_flush = 0; b_theta_empty = 1; #1;
        check("fl_state", b_state, 3);
        wr_seen = 0;
        for (int i = 0; i < 5; i++) begin
            b_cvo = 1; #1;
            wr_seen += int'(b_wr);
            tick;
        end
        b_cvo = 0; #1;
        check("fl_no_writes", wr_seen, 0);
        check("fl_in_flight_0", b_in_flight, 0);
        check("fl_out_count", b_out_count, 2);
        check("fl_state_hold", b_state, 3);
        tick;
        check("fl_to_idle", b_state, 0);

        // backpressure (depth 4): result returns 3 cycles after issue
        s_enable = 1; tick;
        s_theta_empty = 0;
        for (int i = 0; i < 12; i++) begin
            s_cvo = (i >= 3) ? hist[i-3] : 1'b0;
            #1;
            hist[i] = s_rd;
            issues += int'(s_rd);
            tick;
        end
        s_cvo = 0; #1;
        check("bp_issues", issues, 4);
        check("bp_out_count", s_out_count, 4);
        check("bp_in_flight", s_in_flight, 0);
        check("bp_rd_held", s_rd, 0);
        s_out_rd = 1; #1;
        check("bp_rd_same_cycle", s_rd, 0);
        tick; s_out_rd = 0; #1;
        check("bp_rd_next", s_rd, 1);
        check("bp_out_count_3", s_out_count, 3);
        tick;
        check("bp_rd_once", s_rd, 0);
        check("bp_in_flight_1", s_in_flight, 1);
        s_theta_empty = 1; s_cvo = 1; #1;
        check("bp_wr", s_wr, 1);
        tick; s_cvo = 0;
        s_out_rd = 1; repeat (5) tick; s_out_rd = 0; #1;
        check("bp_pop_empty", s_out_count, 0);

        // drain (depth 4)
        s_theta_empty = 0; tick; tick; tick;
        s_enable = 0; #1;
        check("dr_rd_off", s_rd, 0);
        tick;
        check("dr_state", s_state, 2);
        check("dr_no_issue", s_rd, 0);
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            s_cvo = 1; #1;
            wr_seen += int'(s_wr);
            tick;
        end
        s_cvo = 0; #1;
        check("dr_writes", wr_seen, 3);
        tick;
        check("dr_idle", s_state, 0);
        check("dr_out_count", s_out_count, 3);
        s_out_rd = 1; tick; s_out_rd = 0;

        // spurious result (depth 4, idle)
        s_theta_empty = 1; s_cvo = 1; #1;
        check("er_wr", s_wr, 0);
        tick; s_cvo = 0; #1;
        check("er_err", s_err, 1);
        check("er_out_count", s_out_count, 2);

        // reset mid-RUN with 3 in flight
        s_out_rd = 1; tick; tick; s_out_rd = 0;
        s_enable = 1; tick;
        s_theta_empty = 0; tick; tick; tick;
        check("rr_in_flight", s_in_flight, 3);
        check("rr_state_run", s_state, 1);
        #2;
        reset = 1'b1; s_cvo = 1; #1;
        check("rr_state", s_state, 0);
        check("rr_rd", s_rd, 0);
        check("rr_cvi", s_cvi, 0);
        check("rr_wr", s_wr, 0);
        check("rr_in_flight_0", s_in_flight, 0);
        check("rr_out_count", s_out_count, 0);
        check("rr_err", s_err, 0);
        s_cvo = 0;
        tick;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
